// File: rtl/elev_pkg.sv
// Shared lift-system definitions: request code width, idle code, arbiter
// states and the floor/code conversion helpers.
package elev_pkg;

    localparam int REQ_W = 3;
    localparam logic [REQ_W-1:0] REQ_IDLE = 3'd0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EMIT = 2'd1,
        ST_GAP  = 2'd2
    } arb_state_t;

    // Code 0 is reserved for "no request", so floor i travels as i+1.
    function automatic logic [REQ_W-1:0] floor_to_code(input logic [2:0] floor);
        return floor + 3'd1;
    endfunction

    function automatic logic [2:0] code_to_floor(input logic [REQ_W-1:0] code);
        return code - 3'd1;
    endfunction

endpackage

// File: rtl/call_debounce.sv
// One button: 2-flop synchroniser, optional debounce filter (enabled by
// CALL_PANEL_DEBOUNCE_EN) and a one-cycle rising-edge pulse on the clean level.
module call_debounce #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic rise
);

    logic [1:0] sync_r;
    logic       level_s;
    logic       level_d_r;

    // Synchroniser for the asynchronous button input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], btn};
        end
    end

`ifdef CALL_PANEL_DEBOUNCE_EN
    logic [7:0] cnt_r;
    logic       filt_r;

    // Accept a new level only after DEB_CYCLES consecutive differing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r  <= 8'd0;
            filt_r <= 1'b0;
        end else if (sync_r[1] == filt_r) begin
            cnt_r <= 8'd0;
        end else if (cnt_r == 8'(DEB_CYCLES - 1)) begin
            filt_r <= sync_r[1];
            cnt_r  <= 8'd0;
        end else begin
            cnt_r <= cnt_r + 8'd1;
        end
    end

    assign level_s = filt_r;
`else
    assign level_s = sync_r[1];
`endif

    // Previous clean level for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_d_r <= 1'b0;
        end else begin
            level_d_r <= level_s;
        end
    end

    assign rise = level_s & ~level_d_r;

endmodule

// File: rtl/call_panel.sv
// Call-button front end: latches debounced presses per floor, serialises them
// round-robin as request codes and drives the call lamps. Debounce is gated by
// CALL_PANEL_DEBOUNCE_EN.
module call_panel
    import elev_pkg::*;
#(
    parameter int NUM_FLOORS = 4,
    parameter int DEB_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_FLOORS-1:0] btn,
    input  logic                  ready,
    input  logic                  served,
    input  logic [REQ_W-1:0]      served_code,
    output logic [REQ_W-1:0]      req_code,
    output logic [NUM_FLOORS-1:0] lamp
);

    localparam logic [NUM_FLOORS-1:0] ONE = {{(NUM_FLOORS-1){1'b0}}, 1'b1};

    logic [NUM_FLOORS-1:0] rise_s;
    logic [NUM_FLOORS-1:0] pending_r, inflight_r, lamp_r;
    logic [NUM_FLOORS-1:0] served_mask_s, emit_mask_s, inflight_clr_s;
    logic [NUM_FLOORS-1:0] pending_nxt_s, inflight_nxt_s;
    logic                  served_ok_s, found_s, hit_s;
    logic [2:0]            gnt_r, gnt_nxt_s, pick_s, idx_s;
    logic [REQ_W-1:0]      req_r, req_nxt_s;
    arb_state_t            state_r, state_nxt_s;

    for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_btn
        call_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
            .clk   (clk),
            .rst_n (rst_n),
            .btn   (btn[i]),
            .rise  (rise_s[i])
        );
    end

    // Per-floor bookkeeping; a served clear lands before a same-cycle press.
    always_comb begin
        served_ok_s    = served && (served_code != REQ_IDLE) && (served_code <= 3'(NUM_FLOORS));
        served_mask_s  = served_ok_s ? (ONE << code_to_floor(served_code)) : '0;
        emit_mask_s    = (state_r == ST_EMIT) ? (ONE << gnt_r) : '0;
        inflight_clr_s = inflight_r & ~served_mask_s;
        inflight_nxt_s = inflight_clr_s | emit_mask_s;
        pending_nxt_s  = (pending_r & ~emit_mask_s) | (rise_s & ~(pending_r | inflight_clr_s));
    end

    // Round-robin search starting just after the last granted floor.
    always_comb begin
        found_s = 1'b0;
        hit_s   = 1'b0;
        pick_s  = gnt_r;
        idx_s   = gnt_r;
        for (int k = 1; k <= NUM_FLOORS; k++) begin
            idx_s   = 3'((int'(gnt_r) + k) % NUM_FLOORS);
            hit_s   = (pending_r & (ONE << idx_s)) != '0;
            pick_s  = (!found_s && hit_s) ? idx_s : pick_s;
            found_s = found_s | hit_s;
        end
    end

    // Arbiter next-state and registered request code.
    always_comb begin
        state_nxt_s = state_r;
        req_nxt_s   = REQ_IDLE;
        gnt_nxt_s   = gnt_r;
        case (state_r)
            ST_IDLE: begin
                if (found_s && ready) begin
                    state_nxt_s = ST_EMIT;
                    req_nxt_s   = floor_to_code(pick_s);
                    gnt_nxt_s   = pick_s;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_EMIT: state_nxt_s = ST_GAP;
            ST_GAP:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            req_r      <= REQ_IDLE;
            gnt_r      <= 3'(NUM_FLOORS - 1);
            pending_r  <= '0;
            inflight_r <= '0;
            lamp_r     <= '0;
        end else begin
            state_r    <= state_nxt_s;
            req_r      <= req_nxt_s;
            gnt_r      <= gnt_nxt_s;
            pending_r  <= pending_nxt_s;
            inflight_r <= inflight_nxt_s;
            lamp_r     <= pending_nxt_s | inflight_nxt_s;
        end
    end

    assign req_code = req_r;
    assign lamp     = lamp_r;

endmodule

// File: tb/tb_call_panel.sv
// Scoreboard bench for call_panel: expected request codes (with the cycle they
// must appear) are queued by the stimulus and checked by a monitor.
module tb_call_panel;

    localparam int NF  = 4;
    localparam int DEB = 16;
`ifdef CALL_PANEL_DEBOUNCE_EN
    localparam int LAT = DEB + 3;
`else
    localparam int LAT = 3;
`endif

    typedef struct {
        logic [2:0] code;
        int         cyc;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [NF-1:0] btn = '0;
    logic          ready = 1'b1;
    logic          served = 1'b0;
    logic [2:0]    served_code = 3'd0;
    logic [2:0]    req_code;
    logic [NF-1:0] lamp;

    exp_t sb_q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   p;
    int   r;

    call_panel #(.NUM_FLOORS(NF), .DEB_CYCLES(DEB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .ready       (ready),
        .served      (served),
        .served_code (served_code),
        .req_code    (req_code),
        .lamp        (lamp)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every non-zero code must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && req_code != 3'd0) begin
            exp_t e;
            total++;
            if (sb_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_code: got %0d at cycle %0d, required none", req_code, cyc);
            end else begin
                e = sb_q.pop_front();
                if (req_code != e.code || cyc != e.cyc) begin
                    bad++;
                    $display("FAIL req_code: got %0d at cycle %0d, required %0d at cycle %0d",
                             req_code, cyc, e.code, e.cyc);
                end
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_code(input logic [2:0] code, input int at);
        exp_t e;
        e.code = code;
        e.cyc  = at;
        sb_q.push_back(e);
    endtask

    task automatic check_lamp(input string name, input logic [NF-1:0] exp);
        @(negedge clk);
        total++;
        if (lamp !== exp) begin
            bad++;
            $display("FAIL %s: lamp got %b required %b", name, lamp, exp);
        end
    endtask

    task automatic check_req_now(input string name);
        total++;
        if (req_code !== 3'd0) begin
            bad++;
            $display("FAIL %s: req_code got %0d required 0", name, req_code);
        end
    endtask

    task automatic serve(input logic [2:0] code);
        served      = 1'b1;
        served_code = code;
        tick(1);
        served      = 1'b0;
        served_code = 3'd0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        btn   = '0;
        ready = 1'b1;
        served = 1'b0;
        served_code = 3'd0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        do_reset();
        check_req_now("reset_req");
        check_lamp("reset_lamp", 4'b0000);

        // Single long press on floor 2.
        tick(1);
        p = cyc;
        btn[2] = 1'b1;
        expect_code(3'd3, p + LAT + 1);
        tick(LAT - 1);
        check_lamp("lamp2_before", 4'b0000);
        tick(1);
        check_lamp("lamp2_on", 4'b0100);
        tick(40 - LAT);
        btn[2] = 1'b0;
        check_lamp("lamp2_inflight", 4'b0100);
        tick(1);
        serve(3'd3);
        check_lamp("lamp2_served", 4'b0000);
        tick(40);

        // Short glitch on floor 1.
        p = cyc;
        btn[1] = 1'b1;
`ifndef CALL_PANEL_DEBOUNCE_EN
        expect_code(3'd2, p + 4);
`endif
        tick(10);
        btn[1] = 1'b0;
        tick(40);
`ifdef CALL_PANEL_DEBOUNCE_EN
        check_lamp("glitch_lamp", 4'b0000);
`else
        check_lamp("glitch_lamp", 4'b0010);
`endif
        tick(1);
        serve(3'd2);
        check_lamp("glitch_cleared", 4'b0000);

        // Simultaneous floors 0, 1, 3 from reset priority.
        do_reset();
        p = cyc;
        btn = 4'b1011;
        expect_code(3'd1, p + LAT + 1);
        expect_code(3'd2, p + LAT + 4);
        expect_code(3'd4, p + LAT + 7);
        tick(LAT + 8);
        check_lamp("multi_lamp", 4'b1011);
        tick(1);
        btn = '0;
        tick(40);

        // Re-press a lit floor, then served handling including ignored codes.
        btn[1] = 1'b1;
        tick(40);
        check_lamp("dup_lamp", 4'b1011);
        tick(1);
        serve(3'd2);
        check_lamp("served2", 4'b1001);
        tick(1);
        serve(3'd0);
        check_lamp("served_code0", 4'b1001);
        tick(1);
        serve(3'd5);
        check_lamp("served_code5", 4'b1001);
        tick(1);
        serve(3'd1);
        check_lamp("served1", 4'b1000);
        tick(1);
        btn = '0;
        tick(40);

        // Served clear for floor 3 coincides with a new press edge on floor 3.
        p = cyc;
        btn[3] = 1'b1;
        expect_code(3'd4, p + LAT + 1);
        tick(LAT - 1);
        serve(3'd4);
        check_lamp("served_plus_press", 4'b1000);
        tick(5);
        btn = '0;
        serve(3'd4);
        check_lamp("served4", 4'b0000);
        tick(40);

        // Back-pressure: ready low holds the pending floor.
        ready = 1'b0;
        p = cyc;
        btn[3] = 1'b1;
        tick(LAT);
        check_lamp("ready_low_lamp", 4'b1000);
        tick(20);
        r = cyc;
        ready = 1'b1;
        expect_code(3'd4, r + 1);
        tick(3);
        btn = '0;
        serve(3'd4);
        check_lamp("ready_served", 4'b0000);
        tick(40);

        // Reset asserted while a code is being emitted.
        p = cyc;
        btn[0] = 1'b1;
        tick(LAT + 1);
        rst_n = 1'b0;
        btn = '0;
        #1;
        check_req_now("reset_in_emit_req");
        total++;
        if (lamp !== 4'b0000) begin
            bad++;
            $display("FAIL reset_in_emit_lamp: lamp got %b required 0000", lamp);
        end
        tick(2);
        rst_n = 1'b1;
        tick(40);
        check_lamp("after_reset_lamp", 4'b0000);
        check_req_now("after_reset_req");

        total++;
        if (sb_q.size() != 0) begin
            bad++;
            $display("FAIL missing_codes: got %0d outstanding required 0", sb_q.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
